// File: rtl/cola_escritura_reg_if.sv
// Write-back queue bus: producer ports A/M, drain control,
// register-file write port and occupancy/status view.
interface cola_escritura_reg_if #(
  parameter int ANCHO_DATO = 32
);
  logic                  a_valido;
  logic [4:0]            a_rd;
  logic [ANCHO_DATO-1:0] a_dato;
  logic                  a_listo;
  logic                  m_valido;
  logic [4:0]            m_rd;
  logic [ANCHO_DATO-1:0] m_dato;
  logic                  m_listo;
  logic                  drenar_en;
  logic                  reg_escribir;
  logic [4:0]            rd;
  logic [ANCHO_DATO-1:0] dato_escribir;
  logic [31:0]           ocupado;
  logic                  vacio;
  logic                  lleno;

  modport master (
    output a_valido, a_rd, a_dato,
    output m_valido, m_rd, m_dato,
    output drenar_en,
    input  a_listo, m_listo,
    input  reg_escribir, rd, dato_escribir,
    input  ocupado, vacio, lleno
  );

  modport slave (
    input  a_valido, a_rd, a_dato,
    input  m_valido, m_rd, m_dato,
    input  drenar_en,
    output a_listo, m_listo,
    output reg_escribir, rd, dato_escribir,
    output ocupado, vacio, lleno
  );
endinterface

// File: rtl/cola_escritura_reg.sv
// Write-back queue: two producers (A has priority) feed a FIFO
// drained one entry per cycle into the register-file write port.
module cola_escritura_reg #(
  parameter int PROF       = 4,
  parameter int ANCHO_DATO = 32
) (
  input logic                clk,
  input logic                rst,
  cola_escritura_reg_if.slave bus
);
  localparam int PW = $clog2(PROF);
  localparam int CW = PW + 1;

  logic [4:0]            mem_rd   [PROF];
  logic [ANCHO_DATO-1:0] mem_dato [PROF];
  logic [PW-1:0]         rp, wp;
  logic [CW-1:0]         cnt;

  logic                  we_q;
  logic [4:0]            rd_q;
  logic [ANCHO_DATO-1:0] dato_q;

  logic                  vacio, lleno;
  logic                  acc_a, acc_m;
  logic [4:0]            in_rd;
  logic [ANCHO_DATO-1:0] in_dato;
  logic                  push, pop;
  logic [31:0]           occ;

  assign vacio = (cnt == '0);
  assign lleno = (cnt == CW'(PROF));

  // Listo depends only on state and a_valido, never on drenar_en
  assign bus.a_listo = !lleno;
  assign bus.m_listo = !lleno && !bus.a_valido;

  assign acc_a   = bus.a_valido && !lleno;
  assign acc_m   = bus.m_valido && !lleno && !bus.a_valido;
  assign in_rd   = acc_a ? bus.a_rd : bus.m_rd;
  assign in_dato = acc_a ? bus.a_dato : bus.m_dato;
  assign push    = (acc_a || acc_m) && (in_rd != 5'd0);
  assign pop     = bus.drenar_en && !vacio;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_rd[wp]   <= in_rd;
      mem_dato[wp] <= in_dato;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rp  <= '0;
      wp  <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      unique case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_q   <= 1'b0;
      rd_q   <= '0;
      dato_q <= '0;
    end else if (pop) begin
      we_q   <= 1'b1;
      rd_q   <= mem_rd[rp];
      dato_q <= mem_dato[rp];
    end else begin
      we_q   <= 1'b0;
    end
  end

  // Entry i (from head) is live while its offset is below count
  always_comb begin
    occ = '0;
    for (int i = 0; i < PROF; i++) begin
      if (CW'(i) < cnt)
        occ[mem_rd[rp + PW'(i)]] = 1'b1;
    end
    if (we_q) occ[rd_q] = 1'b1;
    occ[0] = 1'b0;
  end

  assign bus.reg_escribir  = we_q;
  assign bus.rd            = rd_q;
  assign bus.dato_escribir = dato_q;
  assign bus.ocupado       = occ;
  assign bus.vacio         = vacio;
  assign bus.lleno         = lleno;
endmodule

// File: tb/tb_cola_escritura_reg.sv
// Bench for cola_escritura_reg: scenario tasks plus a write-port
// monitor popping expected writes from a scoreboard queue.
module tb_cola_escritura_reg;
  logic clk = 1'b0;
  logic rst = 1'b1;

  cola_escritura_reg_if #(.ANCHO_DATO(32)) bus ();

  cola_escritura_reg #(.PROF(4), .ANCHO_DATO(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] d;
  } wr_t;

  wr_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  always @(negedge clk) begin
    if (!rst && bus.reg_escribir) begin
      wr_t e;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_write: rd=%0d dato=%h, required none",
                 bus.rd, bus.dato_escribir);
      end else begin
        e = exp_q.pop_front();
        if (bus.rd !== e.rd || bus.dato_escribir !== e.d) begin
          n_bad++;
          $display("FAIL write_order: got rd=%0d dato=%h, required rd=%0d dato=%h",
                   bus.rd, bus.dato_escribir, e.rd, e.d);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.a_valido = 1'b0;
    bus.a_rd     = '0;
    bus.a_dato   = '0;
    bus.m_valido = 1'b0;
    bus.m_rd     = '0;
    bus.m_dato   = '0;
  endtask

  task automatic test_reset();
    idle();
    bus.drenar_en = 1'b1;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
    n_cmp++;
    if (bus.reg_escribir !== 1'b0) begin
      n_bad++; $display("FAIL rst_we: got %b required 0", bus.reg_escribir);
    end
    n_cmp++;
    if (bus.rd !== 5'd0 || bus.dato_escribir !== 32'd0) begin
      n_bad++; $display("FAIL rst_port: got rd=%0d dato=%h required 0/0",
                        bus.rd, bus.dato_escribir);
    end
    n_cmp++;
    if (bus.vacio !== 1'b1 || bus.lleno !== 1'b0) begin
      n_bad++; $display("FAIL rst_flags: got vacio=%b lleno=%b required 1/0",
                        bus.vacio, bus.lleno);
    end
    n_cmp++;
    if (bus.ocupado !== 32'd0) begin
      n_bad++; $display("FAIL rst_ocupado: got %h required 0", bus.ocupado);
    end
    n_cmp++;
    if (bus.a_listo !== 1'b1) begin
      n_bad++; $display("FAIL rst_a_listo: got %b required 1", bus.a_listo);
    end
  endtask

  task automatic test_single();
    bus.drenar_en = 1'b1;
    bus.a_valido  = 1'b1;
    bus.a_rd      = 5'd5;
    bus.a_dato    = 32'h0000_00AA;
    #1;
    n_cmp++;
    if (bus.a_listo !== 1'b1) begin
      n_bad++; $display("FAIL single_listo: got %b required 1", bus.a_listo);
    end
    exp_q.push_back('{rd: 5'd5, d: 32'hAA});
    step();
    idle();
    n_cmp++;
    if (bus.reg_escribir !== 1'b0 || bus.ocupado !== 32'h20) begin
      n_bad++; $display("FAIL single_k: got we=%b occ=%h required 0/00000020",
                        bus.reg_escribir, bus.ocupado);
    end
    step();
    n_cmp++;
    if (bus.reg_escribir !== 1'b1 || bus.rd !== 5'd5 ||
        bus.dato_escribir !== 32'hAA) begin
      n_bad++; $display("FAIL single_k1: got we=%b rd=%0d dato=%h required 1/5/aa",
                        bus.reg_escribir, bus.rd, bus.dato_escribir);
    end
    n_cmp++;
    if (bus.ocupado !== 32'h20 || bus.vacio !== 1'b1) begin
      n_bad++; $display("FAIL single_occ_k1: got occ=%h vacio=%b required 00000020/1",
                        bus.ocupado, bus.vacio);
    end
    step();
    n_cmp++;
    if (bus.reg_escribir !== 1'b0 || bus.ocupado !== 32'd0) begin
      n_bad++; $display("FAIL single_k2: got we=%b occ=%h required 0/0",
                        bus.reg_escribir, bus.ocupado);
    end
  endtask

  task automatic test_priority();
    bus.drenar_en = 1'b1;
    bus.a_valido  = 1'b1;
    bus.a_rd      = 5'd3;
    bus.a_dato    = 32'h33;
    bus.m_valido  = 1'b1;
    bus.m_rd      = 5'd4;
    bus.m_dato    = 32'h44;
    #1;
    n_cmp++;
    if (bus.a_listo !== 1'b1 || bus.m_listo !== 1'b0) begin
      n_bad++; $display("FAIL prio_listo: got a=%b m=%b required 1/0",
                        bus.a_listo, bus.m_listo);
    end
    exp_q.push_back('{rd: 5'd3, d: 32'h33});
    step();
    bus.a_valido = 1'b0;
    #1;
    n_cmp++;
    if (bus.m_listo !== 1'b1) begin
      n_bad++; $display("FAIL prio_m_listo: got %b required 1", bus.m_listo);
    end
    exp_q.push_back('{rd: 5'd4, d: 32'h44});
    step();
    idle();
    repeat (6) step();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++; $display("FAIL prio_drain: got %0d pending required 0", exp_q.size());
    end
  endtask

  task automatic test_full();
    bus.drenar_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.a_valido = 1'b1;
      bus.a_rd     = 5'(10 + i);
      bus.a_dato   = 32'h100 + 32'(i);
      #1;
      n_cmp++;
      if (bus.a_listo !== 1'b1) begin
        n_bad++; $display("FAIL full_fill_listo%0d: got %b required 1", i, bus.a_listo);
      end
      exp_q.push_back('{rd: 5'(10 + i), d: 32'h100 + 32'(i)});
      step();
    end
    bus.a_rd   = 5'd14;
    bus.a_dato = 32'h104;
    bus.m_valido = 1'b1;
    bus.m_rd     = 5'd15;
    #1;
    n_cmp++;
    if (bus.lleno !== 1'b1 || bus.a_listo !== 1'b0 || bus.m_listo !== 1'b0) begin
      n_bad++; $display("FAIL full_flags: got lleno=%b a=%b m=%b required 1/0/0",
                        bus.lleno, bus.a_listo, bus.m_listo);
    end
    n_cmp++;
    if (bus.ocupado !== 32'h0000_3C00) begin
      n_bad++; $display("FAIL full_ocupado: got %h required 00003c00", bus.ocupado);
    end
    bus.m_valido = 1'b0;
    step();
    step();
    n_cmp++;
    if (bus.lleno !== 1'b1 || bus.reg_escribir !== 1'b0) begin
      n_bad++; $display("FAIL full_hold: got lleno=%b we=%b required 1/0",
                        bus.lleno, bus.reg_escribir);
    end
    bus.drenar_en = 1'b1;
    #1;
    n_cmp++;
    if (bus.a_listo !== 1'b0) begin
      n_bad++; $display("FAIL full_no_relief: got %b required 0", bus.a_listo);
    end
    step();
    n_cmp++;
    if (bus.lleno !== 1'b0 || bus.a_listo !== 1'b1) begin
      n_bad++; $display("FAIL full_relief: got lleno=%b a=%b required 0/1",
                        bus.lleno, bus.a_listo);
    end
    exp_q.push_back('{rd: 5'd14, d: 32'h104});
    step();
    idle();
    repeat (8) step();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++; $display("FAIL full_drain: got %0d pending required 0", exp_q.size());
    end
  endtask

  task automatic test_rd_zero();
    bus.drenar_en = 1'b1;
    bus.a_valido  = 1'b1;
    bus.a_rd      = 5'd0;
    bus.a_dato    = 32'hDEAD;
    #1;
    n_cmp++;
    if (bus.a_listo !== 1'b1) begin
      n_bad++; $display("FAIL rd0_listo: got %b required 1", bus.a_listo);
    end
    step();
    idle();
    n_cmp++;
    if (bus.vacio !== 1'b1 || bus.ocupado !== 32'd0) begin
      n_bad++; $display("FAIL rd0_state: got vacio=%b occ=%h required 1/0",
                        bus.vacio, bus.ocupado);
    end
    step();
    n_cmp++;
    if (bus.reg_escribir !== 1'b0) begin
      n_bad++; $display("FAIL rd0_we: got %b required 0", bus.reg_escribir);
    end
  endtask

  task automatic test_same_rd();
    bus.drenar_en = 1'b1;
    bus.a_valido  = 1'b1;
    bus.a_rd      = 5'd7;
    bus.a_dato    = 32'h1;
    exp_q.push_back('{rd: 5'd7, d: 32'h1});
    step();
    bus.a_dato = 32'h2;
    exp_q.push_back('{rd: 5'd7, d: 32'h2});
    step();
    idle();
    n_cmp++;
    if (bus.ocupado !== 32'h80) begin
      n_bad++; $display("FAIL same_occ_e2: got %h required 00000080", bus.ocupado);
    end
    step();
    n_cmp++;
    if (bus.ocupado !== 32'h80 || bus.dato_escribir !== 32'h2) begin
      n_bad++; $display("FAIL same_occ_e3: got occ=%h dato=%h required 00000080/2",
                        bus.ocupado, bus.dato_escribir);
    end
    step();
    n_cmp++;
    if (bus.ocupado !== 32'd0) begin
      n_bad++; $display("FAIL same_occ_e4: got %h required 0", bus.ocupado);
    end
  endtask

  task automatic test_reset_flush();
    bus.drenar_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.a_valido = 1'b1;
      bus.a_rd     = 5'(20 + i);
      bus.a_dato   = 32'h200 + 32'(i);
      step();
    end
    idle();
    n_cmp++;
    if (bus.ocupado !== 32'h0070_0000) begin
      n_bad++; $display("FAIL flush_pre_occ: got %h required 00700000", bus.ocupado);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++;
    if (bus.reg_escribir !== 1'b0 || bus.vacio !== 1'b1 ||
        bus.ocupado !== 32'd0) begin
      n_bad++; $display("FAIL flush_post: got we=%b vacio=%b occ=%h required 0/1/0",
                        bus.reg_escribir, bus.vacio, bus.ocupado);
    end
    bus.drenar_en = 1'b1;
    repeat (5) step();
    n_cmp++;
    if (bus.reg_escribir !== 1'b0 || bus.vacio !== 1'b1) begin
      n_bad++; $display("FAIL flush_stale: got we=%b vacio=%b required 0/1",
                        bus.reg_escribir, bus.vacio);
    end
  endtask

  initial begin
    idle();
    bus.drenar_en = 1'b0;
    test_reset();
    test_single();
    test_priority();
    test_full();
    test_rd_zero();
    test_same_rd();
    test_reset_flush();
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
